// File: rtl/benes_route_sequencer_if.sv
// Bundle of configuration-write, command and select-output signals for
// benes_route_sequencer. The master side (controller/requester) drives
// the table writes and commands; the slave side (the sequencer) drives
// the interconnect selects and status.
//
// Handshake: a command transfers at a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the sequencer is
// idle, so the requester simply holds cmd_valid (and the command fields)
// until it sees the transfer; nothing is queued.
interface benes_route_sequencer_if #(
  parameter int STAGE_NUM  = 9,
  parameter int SWITCH_NUM = 16,
  parameter int CFG_DEPTH  = 16,
  parameter int LEN_W      = 16
);
  localparam int IDX_W = $clog2(CFG_DEPTH);
  localparam int STG_W = $clog2(STAGE_NUM);

  // table write port
  logic                   cfg_wr_en;
  logic                   cfg_wr_net;
  logic [IDX_W-1:0]       cfg_wr_idx;
  logic [STG_W-1:0]       cfg_wr_stage;
  logic [SWITCH_NUM-1:0]  cfg_wr_data;

  // command port
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [IDX_W-1:0]       cmd_r2m_idx;
  logic [IDX_W-1:0]       cmd_m2r_idx;
  logic [LEN_W-1:0]       cmd_len;

  // interconnect drive and status
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_module_select;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_slot_select;
  logic                   o_sel_valid;
  logic                   o_busy;
  logic                   o_done;

  // current FSM state, for observation only
  logic [2:0]             dbg_state;

  modport master (
    output cfg_wr_en, cfg_wr_net, cfg_wr_idx, cfg_wr_stage, cfg_wr_data,
    output cmd_valid, cmd_r2m_idx, cmd_m2r_idx, cmd_len,
    input  cmd_ready, o_module_select, o_slot_select, o_sel_valid,
    input  o_busy, o_done, dbg_state
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_net, cfg_wr_idx, cfg_wr_stage, cfg_wr_data,
    input  cmd_valid, cmd_r2m_idx, cmd_m2r_idx, cmd_len,
    output cmd_ready, o_module_select, o_slot_select, o_sel_valid,
    output o_busy, o_done, dbg_state
  );
endinterface

// File: rtl/benes_route_sequencer.sv
// Benes route sequencer: holds precomputed per-stage switch settings for
// the RAM-to-module (R2M) and module-to-RAM (M2R) networks, applies a
// selected pair of entries for a commanded number of beats, waits for the
// interconnect pipeline to drain and then pulses o_done.
// R2M entries drive o_module_select, M2R entries drive o_slot_select.
//
// Optional build macro BENES_CFG_IDENTITY_EN: entry 0 of both tables is
// hardwired to all-zero selects (identity permutation), writes to index 0
// are dropped and only CFG_DEPTH-1 entries per table are stored.
// NET_LATENCY must be at least 1.
module benes_route_sequencer #(
  parameter int STAGE_NUM   = 9,
  parameter int SWITCH_NUM  = 16,
  parameter int CFG_DEPTH   = 16,
  parameter int LEN_W       = 16,
  parameter int NET_LATENCY = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  benes_route_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(CFG_DEPTH);
  localparam int STG_W = $clog2(STAGE_NUM);
  localparam int DRN_W = $clog2(NET_LATENCY + 1);
`ifdef BENES_CFG_IDENTITY_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] sel_t;

  sel_t r2m_tab_q [BASE:CFG_DEPTH-1];
  sel_t m2r_tab_q [BASE:CFG_DEPTH-1];

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] r2m_idx_q, m2r_idx_q;
  logic [LEN_W-1:0] len_q, beat_q;
  logic [DRN_W-1:0] drn_q;
  sel_t             mod_sel_q, slot_sel_q;
  sel_t             r2m_rd, m2r_rd;
  logic             wr_ok;

  // Stage rows beyond the last Benes stage do not exist; such writes drop.
`ifdef BENES_CFG_IDENTITY_EN
  assign wr_ok = bus.cfg_wr_en
              && ({1'b0, bus.cfg_wr_stage} < (STG_W + 1)'(STAGE_NUM))
              && (bus.cfg_wr_idx != '0);
  assign r2m_rd = (r2m_idx_q == '0) ? '0 : r2m_tab_q[r2m_idx_q];
  assign m2r_rd = (m2r_idx_q == '0) ? '0 : m2r_tab_q[m2r_idx_q];
`else
  assign wr_ok = bus.cfg_wr_en
              && ({1'b0, bus.cfg_wr_stage} < (STG_W + 1)'(STAGE_NUM));
  assign r2m_rd = r2m_tab_q[r2m_idx_q];
  assign m2r_rd = m2r_tab_q[m2r_idx_q];
`endif

  // Configuration table storage; a write landing on the LOAD edge is seen
  // by the next command only (the LOAD copy samples the old contents).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = BASE; i < CFG_DEPTH; i++) begin
        r2m_tab_q[i] <= '0;
        m2r_tab_q[i] <= '0;
      end
    end else if (wr_ok) begin
      if (bus.cfg_wr_net) begin
        m2r_tab_q[bus.cfg_wr_idx][bus.cfg_wr_stage] <= bus.cfg_wr_data;
      end else begin
        r2m_tab_q[bus.cfg_wr_idx][bus.cfg_wr_stage] <= bus.cfg_wr_data;
      end
    end
  end

  // Next-state logic for IDLE -> LOAD -> RUN -> DRAIN -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.cmd_valid) state_d = ST_LOAD;
      ST_LOAD:  state_d = (len_q != '0) ? ST_RUN : ST_DRAIN;
      ST_RUN:   if (beat_q == len_q - 1'b1) state_d = ST_DRAIN;
      ST_DRAIN: if (drn_q == DRN_W'(NET_LATENCY - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, command latch, beat/drain counters and the output select copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      r2m_idx_q  <= '0;
      m2r_idx_q  <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      drn_q      <= '0;
      mod_sel_q  <= '0;
      slot_sel_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r2m_idx_q <= bus.cmd_r2m_idx;
            m2r_idx_q <= bus.cmd_m2r_idx;
            len_q     <= bus.cmd_len;
            beat_q    <= '0;
            drn_q     <= '0;
          end
        end
        ST_LOAD: begin
          mod_sel_q  <= r2m_rd;
          slot_sel_q <= m2r_rd;
        end
        ST_RUN:   beat_q <= beat_q + 1'b1;
        ST_DRAIN: drn_q  <= drn_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready       = (state_q == ST_IDLE);
  assign bus.o_busy          = (state_q != ST_IDLE);
  assign bus.o_sel_valid     = (state_q == ST_RUN);
  assign bus.o_done          = (state_q == ST_DONE);
  assign bus.o_module_select = mod_sel_q;
  assign bus.o_slot_select   = slot_sel_q;
  assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_benes_route_sequencer.sv
// Directed + randomized bench for benes_route_sequencer. A table model
// plus the command timing rule (beats in cycles 2..len+1 after acceptance,
// done at len+NET_LATENCY+2) give the expected values for every cycle.
module tb_benes_route_sequencer;
  localparam int STAGE_NUM   = 9;
  localparam int SWITCH_NUM  = 16;
  localparam int CFG_DEPTH   = 16;
  localparam int LEN_W       = 16;
  localparam int NET_LATENCY = 3;
  localparam int IDX_W       = $clog2(CFG_DEPTH);
  localparam int STG_W       = $clog2(STAGE_NUM);
  localparam int SELW        = STAGE_NUM * SWITCH_NUM;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] sel_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  benes_route_sequencer_if #(
    .STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM),
    .CFG_DEPTH(CFG_DEPTH), .LEN_W(LEN_W)
  ) bus ();

  benes_route_sequencer #(
    .STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM), .CFG_DEPTH(CFG_DEPTH),
    .LEN_W(LEN_W), .NET_LATENCY(NET_LATENCY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // reference model state
  logic [SWITCH_NUM-1:0] r2m_m [CFG_DEPTH][STAGE_NUM];
  logic [SWITCH_NUM-1:0] m2r_m [CFG_DEPTH][STAGE_NUM];
  sel_t prev_mod, prev_slot;
  int   total    = 0;
  int   pass_cnt = 0;

  function automatic void model_clear();
    for (int i = 0; i < CFG_DEPTH; i++)
      for (int s = 0; s < STAGE_NUM; s++) begin
        r2m_m[i][s] = '0;
        m2r_m[i][s] = '0;
      end
    prev_mod  = '0;
    prev_slot = '0;
  endfunction

  function automatic void model_write(input bit net, input int idx,
                                      input int stage, input logic [SWITCH_NUM-1:0] data);
    if (stage >= STAGE_NUM) return;
`ifdef BENES_CFG_IDENTITY_EN
    if (idx == 0) return;
`endif
    if (net) m2r_m[idx][stage] = data;
    else     r2m_m[idx][stage] = data;
  endfunction

  function automatic sel_t model_entry(input bit net, input int idx);
    sel_t e;
    for (int s = 0; s < STAGE_NUM; s++)
      e[s] = net ? m2r_m[idx][s] : r2m_m[idx][s];
`ifdef BENES_CFG_IDENTITY_EN
    if (idx == 0) e = '0;
`endif
    return e;
  endfunction

  // scoreboard comparison
  task automatic chk(input string tag, input logic [SELW-1:0] obs,
                     input logic [SELW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver: one table row write while idle (entered and left at negedge)
  task automatic cfg_write(input bit net, input int idx, input int stage,
                           input logic [SWITCH_NUM-1:0] data);
    bus.cfg_wr_en    = 1'b1;
    bus.cfg_wr_net   = net;
    bus.cfg_wr_idx   = IDX_W'(idx);
    bus.cfg_wr_stage = STG_W'(stage);
    bus.cfg_wr_data  = data;
    model_write(net, idx, stage, data);
    @(negedge clk);
    bus.cfg_wr_en = 1'b0;
  endtask

  // driver + per-cycle checker for one command; optional table write at
  // cycle wr_k after acceptance (0 = none); hold keeps cmd_valid asserted.
  task automatic run_cmd(input int r, input int m, input int len, input bit hold,
                         input int wr_k, input bit wr_net, input int wr_idx,
                         input int wr_stage, input logic [SWITCH_NUM-1:0] wr_data);
    sel_t em, es;
    int   done_k, last;
    done_k = len + NET_LATENCY + 2;
    last   = done_k + 1;
    em = '0;
    es = '0;
    chk("ready_before_cmd", bus.cmd_ready, 1'b1);
    bus.cmd_r2m_idx = IDX_W'(r);
    bus.cmd_m2r_idx = IDX_W'(m);
    bus.cmd_len     = LEN_W'(len);
    bus.cmd_valid   = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      bus.cfg_wr_en = 1'b0;
      if (k == 1) begin
        if (!hold) bus.cmd_valid = 1'b0;
        em = model_entry(1'b0, r);
        es = model_entry(1'b1, m);
      end
      chk("sel_valid", bus.o_sel_valid, (k >= 2 && k <= len + 1));
      chk("done",      bus.o_done,      (k == done_k));
      chk("busy",      bus.o_busy,      (k <= done_k));
      chk("cmd_ready", bus.cmd_ready,   (k > done_k));
      if (k == 1) begin
        chk("mod_sel_hold",  bus.o_module_select, prev_mod);
        chk("slot_sel_hold", bus.o_slot_select,   prev_slot);
      end else begin
        chk("mod_sel",  bus.o_module_select, em);
        chk("slot_sel", bus.o_slot_select,   es);
      end
      if (k == wr_k) begin
        bus.cfg_wr_en    = 1'b1;
        bus.cfg_wr_net   = wr_net;
        bus.cfg_wr_idx   = IDX_W'(wr_idx);
        bus.cfg_wr_stage = STG_W'(wr_stage);
        bus.cfg_wr_data  = wr_data;
        model_write(wr_net, wr_idx, wr_stage, wr_data);
      end
    end
    bus.cfg_wr_en = 1'b0;
    prev_mod  = em;
    prev_slot = es;
  endtask

  initial begin
    int r, m, len, wk;
    rst_n            = 1'b0;
    bus.cfg_wr_en    = 1'b0;
    bus.cfg_wr_net   = 1'b0;
    bus.cfg_wr_idx   = '0;
    bus.cfg_wr_stage = '0;
    bus.cfg_wr_data  = '0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_r2m_idx  = '0;
    bus.cmd_m2r_idx  = '0;
    bus.cmd_len      = '0;
    model_clear();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sel_valid", bus.o_sel_valid, 1'b0);
    chk("rst_busy",      bus.o_busy,      1'b0);
    chk("rst_done",      bus.o_done,      1'b0);
    chk("rst_mod_sel",   bus.o_module_select, '0);
    chk("rst_slot_sel",  bus.o_slot_select,   '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // basic command: R2M idx3 walking-one rows, M2R idx5 all ones
    for (int s = 0; s < STAGE_NUM; s++) begin
      cfg_write(1'b0, 3, s, SWITCH_NUM'(1) << s);
      cfg_write(1'b1, 5, s, 16'hFFFF);
    end
    run_cmd(3, 5, 4, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // rewrite active R2M entry during RUN; visible only on next command
    run_cmd(3, 5, 4, 1'b0, 3, 1'b0, 3, 0, 16'hAAAA);
    run_cmd(3, 5, 4, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // zero-length command
    run_cmd(3, 5, 0, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // write landing on the LOAD edge: old value read, new one next time
    run_cmd(3, 5, 2, 1'b0, 1, 1'b1, 5, 2, 16'h0F0F);
    run_cmd(3, 5, 2, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // out-of-range stage row is dropped
    cfg_write(1'b0, 3, 12, 16'h5555);
    run_cmd(3, 5, 1, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // cmd_valid held through a command: next accepted right after o_done
    run_cmd(3, 5, 3, 1'b1, 0, 1'b0, 0, 0, 16'h0);
    run_cmd(3, 5, 3, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // maximum beat count
    run_cmd(5, 3, (1 << LEN_W) - 1, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // reset during the second RUN beat
    bus.cmd_r2m_idx = IDX_W'(3);
    bus.cmd_m2r_idx = IDX_W'(5);
    bus.cmd_len     = LEN_W'(4);
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_second_beat", bus.o_sel_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel_valid", bus.o_sel_valid, 1'b0);
    chk("mid_rst_busy",      bus.o_busy,      1'b0);
    chk("mid_rst_mod_sel",   bus.o_module_select, '0);
    chk("mid_rst_slot_sel",  bus.o_slot_select,   '0);
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", bus.o_done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", bus.o_done, 1'b0);
    run_cmd(3, 5, 2, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // entry 0: writable normally, identity when the feature is built in
    cfg_write(1'b0, 0, 0, 16'h1234);
    cfg_write(1'b1, 0, 0, 16'h1234);
    run_cmd(0, 0, 1, 1'b0, 0, 1'b0, 0, 0, 16'h0);

    // randomized commands with random table traffic
    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 4; w++)
        cfg_write(1'($urandom_range(0, 1)), $urandom_range(0, CFG_DEPTH - 1),
                  $urandom_range(0, 15), 16'($urandom));
      r   = $urandom_range(0, CFG_DEPTH - 1);
      m   = $urandom_range(0, CFG_DEPTH - 1);
      len = $urandom_range(0, 12);
      wk  = $urandom_range(0, len + NET_LATENCY + 2);
      run_cmd(r, m, len, 1'b0, wk, 1'($urandom_range(0, 1)),
              $urandom_range(0, CFG_DEPTH - 1), $urandom_range(0, STAGE_NUM - 1),
              16'($urandom));
    end

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
- Upstream control stage for the buffer/module Benes interconnect.
- Stores precomputed per-stage switch settings for the RAM-to-module (R2M) and module-to-RAM (M2R) networks in a small configuration table.
- On command, drives the selected settings onto the interconnect's module-select and slot-select inputs for a programmed number of cycles.
- After the last beat, waits for the network pipeline to drain, then signals completion.

Parameters:
- STAGE_NUM, 9, Benes stages (2*log2(SIZE)-1 for SIZE=32).
- SWITCH_NUM, 16, 2x2 switches per stage (SIZE/2).
- CFG_DEPTH, 16, configuration entries per network; power of two.
- LEN_W, 16, width of the beat-count field.
- NET_LATENCY, 3, interconnect latency in cycles from select change to settled output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  table write strobe
- cfg_wr_net  in  1  0=R2M table, 1=M2R table
- cfg_wr_idx  in  log2(CFG_DEPTH)  entry index
- cfg_wr_stage  in  log2ceil(STAGE_NUM)  stage row within entry
- cfg_wr_data  in  SWITCH_NUM  switch settings for that row
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_r2m_idx  in  log2(CFG_DEPTH)  R2M entry to apply
- cmd_m2r_idx  in  log2(CFG_DEPTH)  M2R entry to apply
- cmd_len  in  LEN_W  number of valid beats
- o_module_select  out  [STAGE_NUM] x SWITCH_NUM  to interconnect i_module_select
- o_slot_select  out  [STAGE_NUM] x SWITCH_NUM  to interconnect i_slot_select
- o_sel_valid  out  1  selects are applied this cycle
- o_busy  out  1  state != IDLE
- o_done  out  1  single-cycle completion pulse

Behaviour:
- Reset (async):
  - State=IDLE; cmd_ready=1 after reset release.
  - o_module_select and o_slot_select all zero; o_sel_valid=0; o_busy=0; o_done=0.
  - Both tables are cleared to zero.
- Table write:
  - Takes effect at the clk edge when cfg_wr_en=1. Accepted in any state.
  - cfg_wr_stage >= STAGE_NUM: write is ignored.
  - Writes never alter selects already latched for the running command.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
  - IDLE: cmd_valid & cmd_ready at edge T -> LOAD. Indices and cmd_len are latched.
  - LOAD (cycle T+1): the full entries are read and copied into the output select registers. Next state is RUN if len != 0, else DRAIN.
  - RUN: o_sel_valid=1 from cycle T+2 for exactly len cycles. A beat counter runs 0..len-1; at len-1 the next state is DRAIN.
  - DRAIN: o_sel_valid=0, selects held; counts NET_LATENCY cycles, then DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Output select registers hold their last values in IDLE; they are not zeroed after a command.
- Same-cycle write to an entry being read in LOAD: the read returns the old value (read-before-write).
- cmd_valid while busy: ignored (cmd_ready=0). There is no queue; the requester holds cmd_valid.
- cmd_len = 2^LEN_W-1: the counter must not wrap early; exactly that many beats are issued.
- cmd_len=0: sequence is LOAD, DRAIN (NET_LATENCY cycles), DONE. o_sel_valid is never asserted.
- Reset asserted mid-operation: immediate return to reset values. No o_done is emitted.
- Total command time is len + NET_LATENCY + 2 cycles from acceptance to the o_done cycle, inclusive of LOAD and DONE.

Optional Feature:
- Macro: BENES_CFG_IDENTITY_EN.
- Defined:
  - Entry 0 of both tables is hardwired to all-zero selects (all switches straight, identity permutation).
  - Writes to index 0 are ignored.
  - Storage is CFG_DEPTH-1 entries per table.
- Undefined: entry 0 is an ordinary writable entry.

Test Plan:
- Write R2M idx 3 with stage s = 16'h0001<<s, M2R idx 5 with 16'hFFFF; command r2m=3, m2r=5, len=4 accepted at T -> o_sel_valid high T+2..T+5 with those patterns; o_done at T+9 (NET_LATENCY=3).
- cmd_len=0 accepted at T -> o_sel_valid never high; o_done at T+5; cmd_ready returns at T+6.
- During RUN, rewrite the active R2M entry to 16'hAAAA -> outputs unchanged until a new command; the next command using that index shows 16'hAAAA.
- cmd_valid held high through an active command -> the second command is accepted only in the cycle after o_done; no beats are lost or duplicated.
- Assert rst_n low in the 2nd RUN beat -> all outputs zero immediately, no o_done; the table is cleared, so the next command with idx 3 drives zeros.
- With BENES_CFG_IDENTITY_EN: write 16'h1234 to idx 0, command idx 0 len=1 -> selects all zero. Without the macro -> selects are 16'h1234 (stage 0 row).
